// File: rtl/cpu_pkg.sv
// Shared core definitions: redirect priorities, default vectors and the PC bus width.
`ifndef CPU_PKG_PC_BUS
`define CPU_PKG_PC_BUS
`define PC_BUS 32
`endif

package cpu_pkg;

  localparam int unsigned PC_BUS_W = `PC_BUS;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

  // Encoded so that a larger value means a higher redirect priority.
  typedef enum logic [2:0] {
    REDIR_NONE = 3'd0,
    REDIR_RET  = 3'd1,
    REDIR_BR   = 3'd2,
    REDIR_ERET = 3'd3,
    REDIR_EXC  = 3'd4
  } redir_e;

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: pipeline controls and redirects in, fetch request and RAS status out.
interface fetch_pc_gen_if
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_BUS_W
);
  logic                stall;
  logic                fetch_ready;
  logic                exc_valid;
  logic                eret_valid;
  logic [PC_WIDTH-1:0] eret_target;
  logic                br_valid;
  logic [PC_WIDTH-1:0] br_target;
  logic                call_valid;
  logic [PC_WIDTH-1:0] call_ret_addr;
  logic                ret_valid;
  logic [PC_WIDTH-1:0] pc_out;
  logic                pc_valid;
  logic                ras_empty;
  logic                ret_miss;

  modport master (
    output stall, fetch_ready, exc_valid, eret_valid, eret_target,
           br_valid, br_target, call_valid, call_ret_addr, ret_valid,
    input  pc_out, pc_valid, ras_empty, ret_miss
  );

  modport slave (
    input  stall, fetch_ready, exc_valid, eret_valid, eret_target,
           br_valid, br_target, call_valid, call_ret_addr, ret_valid,
    output pc_out, pc_valid, ras_empty, ret_miss
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack with saturating occupancy; oldest entry is overwritten when full.
module pc_ras #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_addr,
  output logic [PC_WIDTH-1:0] top_c,
  output logic                avail_c,
  output logic                empty,
  output logic                ret_miss
);
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]    top, top_next, wr_idx;
  logic [CNT_W-1:0]    count, count_next;
  logic                do_pop;

  always_comb begin
    avail_c    = (count != '0);
    top_c      = mem[top];
    do_pop     = pop & avail_c;
    top_next   = top;
    count_next = count;
    wr_idx     = top + PTR_W'(1);
    if (push && do_pop) begin
      // Call and return together: replace the top in place, occupancy unchanged.
      wr_idx = top;
    end else if (push) begin
      top_next   = top + PTR_W'(1);
      count_next = (count == CNT_W'(RAS_DEPTH)) ? count : count + CNT_W'(1);
    end else if (do_pop) begin
      top_next   = top - PTR_W'(1);
      count_next = count - CNT_W'(1);
    end
  end

  // Entry storage carries no reset; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top      <= '0;
      count    <= '0;
      empty    <= 1'b1;
      ret_miss <= 1'b0;
    end else begin
      top      <= top_next;
      count    <= count_next;
      empty    <= (count_next == '0);
      ret_miss <= pop & ~avail_c;
    end
  end
endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC register with prioritised redirect select, held-redirect register and RAS return prediction.
module fetch_pc_gen
  import cpu_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = PC_BUS_W,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0]  EXC_VECTOR   = PC_WIDTH'(EXC_VECTOR_DEFAULT),
  parameter int unsigned          STEP         = 4,
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_pc_gen_if.slave bus
);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(STEP - 1);
  localparam logic [PC_WIDTH-1:0] STEP_W     = PC_WIDTH'(STEP);

  logic [PC_WIDTH-1:0] pc, pend_tgt, live_tgt, cand_tgt, ras_top_c;
  redir_e              pend_pri, live_pri, cand_pri;
  logic                pc_valid, adv_c, take_live_c, ras_avail_c, ras_empty, ret_miss;

  pc_ras #(
    .PC_WIDTH  (PC_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.call_valid),
    .pop       (bus.ret_valid),
    .push_addr (bus.call_ret_addr),
    .top_c     (ras_top_c),
    .avail_c   (ras_avail_c),
    .empty     (ras_empty),
    .ret_miss  (ret_miss)
  );

  // Live source select, then arbitration against the held redirect (ties favour live).
  always_comb begin
    live_pri = REDIR_NONE;
    live_tgt = '0;
    if (bus.exc_valid) begin
      live_pri = REDIR_EXC;
      live_tgt = EXC_VECTOR;
    end else if (bus.eret_valid) begin
      live_pri = REDIR_ERET;
      live_tgt = bus.eret_target;
    end else if (bus.br_valid) begin
      live_pri = REDIR_BR;
      live_tgt = bus.br_target;
    end else if (bus.ret_valid && ras_avail_c) begin
      live_pri = REDIR_RET;
      live_tgt = ras_top_c;
    end
    live_tgt    = live_tgt & ALIGN_MASK;
    take_live_c = (live_pri != REDIR_NONE) && (live_pri >= pend_pri);
    cand_pri    = take_live_c ? live_pri : pend_pri;
    cand_tgt    = take_live_c ? live_tgt : pend_tgt;
    adv_c       = pc_valid & ~bus.stall & bus.fetch_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_VECTOR;
      pc_valid <= 1'b0;
      pend_pri <= REDIR_NONE;
      pend_tgt <= '0;
    end else begin
      pc_valid <= 1'b1;
      if (adv_c) begin
        pc       <= (cand_pri != REDIR_NONE) ? cand_tgt : pc + STEP_W;
        pend_pri <= REDIR_NONE;
        pend_tgt <= '0;
      end else if (take_live_c) begin
        pend_pri <= live_pri;
        pend_tgt <= live_tgt;
      end
    end
  end

  assign bus.pc_out    = pc;
  assign bus.pc_valid  = pc_valid;
  assign bus.ras_empty = ras_empty;
  assign bus.ret_miss  = ret_miss;
endmodule
